array_loader: RTL and testbench
===============================

ARRAY_LOADER -- requirements
Module: array_loader

Interface
REQ-001 Parameter BASE_ADDR, default 64'd0: byte address of element 1 in data memory.
REQ-002 Parameter NUM_ELEMS, default 8: number of 64-bit elements written per load (legal 1..8).
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  load request, sampled per cycle.
REQ-006 load_data  input  512  packed source array; element k (k=1..8) occupies bits [64k-1:64k-64].
REQ-007 mem_addr  output  64  data-memory write byte address.
REQ-008 mem_wdata  output  64  data-memory write data.
REQ-009 mem_we  output  1  write request; acts as valid.
REQ-010 mem_ready  input  1  memory accepts the current write this cycle.
REQ-011 cpu_hold  output  1  holds the processor pipeline (stall) while the array is not loaded.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  array fully written; level signal.
REQ-014 count  output  4  number of elements accepted so far in the current load.

Function
REQ-015 FSM states SHALL be IDLE, WRITE, DONE; encoding free.
REQ-016 IDLE: start=1 SHALL capture load_data into an internal shadow register, clear count, and enter WRITE next cycle.
REQ-017 WRITE: mem_we=1, mem_addr=BASE_ADDR+8*count, mem_wdata=shadow element (count+1); all registered outputs.
REQ-018 Write accepted only on a cycle with mem_we=1 and mem_ready=1; count increments by 1 on acceptance.
REQ-019 mem_addr/mem_wdata SHALL hold stable while mem_we=1 and mem_ready=0 (no drop, no skip).
REQ-020 Acceptance of element NUM_ELEMS SHALL move to DONE next cycle; mem_we=0 in that cycle; no extra write issued.
REQ-021 DONE: done=1, busy=0, cpu_hold=0, count=NUM_ELEMS; held until start or reset.
REQ-022 start in DONE SHALL re-capture load_data and restart as in REQ-016; done falls, cpu_hold rises in the next cycle.
REQ-023 start while in WRITE SHALL be ignored; shadow register and count unaffected.
REQ-024 Changes on load_data after capture SHALL NOT affect the data written.
REQ-025 busy=1 exactly in WRITE; cpu_hold=1 in IDLE and WRITE.
REQ-026 First write address = BASE_ADDR; address increments by 8 per element; 64-bit wrap-around permitted, no error.
REQ-027 Minimum load latency with mem_ready tied high: start cycle + NUM_ELEMS write cycles, done asserted at cycle NUM_ELEMS+1 after start sampled.

Reset
REQ-028 reset=1 SHALL force IDLE at the next edge: mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, count=0, cpu_hold=1.
REQ-029 reset mid-load SHALL abort immediately; partially written memory contents are not retracted; no further writes issue.
REQ-030 reset has priority over start in the same cycle.

Configuration
REQ-031 Macro ARRAY_LOADER_CHECKSUM_EN defined: extra output checksum, output, 64 bits = modulo-2^64 sum of accepted mem_wdata values of the current load, cleared to 0 on reset and on load capture, updated the cycle after each acceptance.
REQ-032 Macro undefined: no checksum port, no adder logic; all other behaviour identical.

Verification
REQ-033 Reset then start with elements 1..8 = 5,3,8,1,9,2,7,4, mem_ready=1 -> writes to 0x00..0x38 with data 5,3,8,1,9,2,7,4 on 8 consecutive cycles; done=1, cpu_hold=0, count=8 next cycle.
REQ-034 Same load, mem_ready low for 3 cycles during element 3 -> addr 0x10, data 8 held stable for 3 cycles, single acceptance, total 11 write cycles.
REQ-035 Pulse start again during WRITE at element 4 -> ignored; sequence and count unchanged.
REQ-036 Assert reset during element 5 -> next cycle mem_we=0, count=0, cpu_hold=1, done=0; fresh start writes from BASE_ADDR.
REQ-037 BASE_ADDR=0x100, NUM_ELEMS=3, start in DONE with new data 10,20,30 -> writes 0x100/10, 0x108/20, 0x110/30; done re-asserts.
REQ-038 With ARRAY_LOADER_CHECKSUM_EN, REQ-033 data -> checksum=39 after done; two elements 0xFFFFFFFFFFFFFFFF and 2 -> checksum=1.

Source files
------------

// File: rtl/array_loader.sv
// Loads a 512-bit packed array (up to 8 x 64-bit elements) into data memory and stalls the CPU until done.
// Latency: first write is presented the cycle after start; done rises the cycle after the last acceptance.
// Backpressure: mem_we acts as valid, mem_ready as ready; address and data hold while mem_ready is low.
// Optional feature: define ARRAY_LOADER_CHECKSUM_EN to add a 64-bit running checksum output.
module array_loader #(
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter int          NUM_ELEMS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] load_data,
    output logic [63:0]  mem_addr,
    output logic [63:0]  mem_wdata,
    output logic         mem_we,
    input  logic         mem_ready,
    output logic         cpu_hold,
    output logic         busy,
    output logic         done,
    output logic [3:0]   count
`ifdef ARRAY_LOADER_CHECKSUM_EN
    ,
    output logic [63:0]  checksum
`endif
);

    localparam logic [3:0] LAST = 4'(NUM_ELEMS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q,     state_d;
    logic [511:0]   shadow_q,    shadow_d;
    logic [3:0]     count_q,     count_d;
    logic [63:0]    mem_addr_q,  mem_addr_d;
    logic [63:0]    mem_wdata_q, mem_wdata_d;
    logic           mem_we_q,    mem_we_d;
    logic [3:0]     cnt_inc;
    logic [2:0]     nxt_idx;
    logic           capture;
    logic           accept;

`ifdef ARRAY_LOADER_CHECKSUM_EN
    logic [63:0]    checksum_q,  checksum_d;
`endif

    // Next-state logic: capture on start outside WRITE, step through elements on each accepted write.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        count_d     = count_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        cnt_inc     = count_q + 4'd1;
        // Zero-based index of the element that follows the one currently presented.
        nxt_idx     = cnt_inc[2:0];
        capture     = 1'b0;
        accept      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                capture = start;
            end
            S_WRITE: begin
                // start is deliberately ignored here so an in-flight load cannot be disturbed.
                accept = mem_we_q && mem_ready;
                if (accept) begin
                    count_d = cnt_inc;
                    if (cnt_inc == LAST) begin
                        state_d  = S_DONE;
                        mem_we_d = 1'b0;
                    end else begin
                        mem_addr_d  = mem_addr_q + 64'd8;
                        mem_wdata_d = shadow_q[{nxt_idx, 6'b0} +: 64];
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                mem_we_d = 1'b0;
            end
        endcase

        if (capture) begin
            state_d     = S_WRITE;
            shadow_d    = load_data;
            count_d     = 4'd0;
            mem_addr_d  = BASE_ADDR;
            mem_wdata_d = load_data[63:0];
            mem_we_d    = 1'b1;
        end
    end

`ifdef ARRAY_LOADER_CHECKSUM_EN
    // Running sum of accepted write data, restarted whenever a new array is captured.
    always_comb begin
        checksum_d = checksum_q;
        if (capture) begin
            checksum_d = 64'd0;
        end else if (accept) begin
            checksum_d = checksum_q + mem_wdata_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= 64'd0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    // State and registered memory-port outputs; reset aborts any load in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            count_q     <= 4'd0;
            mem_addr_q  <= 64'd0;
            mem_wdata_q <= 64'd0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign count     = count_q;
    assign busy      = (state_q == S_WRITE);
    assign done      = (state_q == S_DONE);
    // The CPU is held until the array is completely in memory.
    assign cpu_hold  = (state_q != S_DONE);

endmodule

// File: tb/tb_array_loader.sv
// Scoreboard bench for array_loader: two instances (default, and BASE_ADDR=0x100 / NUM_ELEMS=3).
// Expected writes are queued at start time; per-instance monitors compare every presented write.
// Stall cycles are compared against the queue head to confirm address/data hold under backpressure.
module tb_array_loader;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] d;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start0, start1;
    logic [511:0] ld0, ld1;
    logic [63:0]  addr0, addr1, wd0, wd1;
    logic         we0, we1, rdy0, rdy1;
    logic         hold0, hold1, busy0, busy1, done0, done1;
    logic [3:0]   cnt0, cnt1;
`ifdef ARRAY_LOADER_CHECKSUM_EN
    logic [63:0]  cs0, cs1;
`endif

    wr_t q0[$];
    wr_t q1[$];
    int  checks = 0;
    int  errors = 0;
    int  we_cyc0 = 0;
    int  we_cyc1 = 0;

    always #5 clk = ~clk;

    array_loader dut0 (
        .clk(clk), .reset(rst), .start(start0), .load_data(ld0),
        .mem_addr(addr0), .mem_wdata(wd0), .mem_we(we0), .mem_ready(rdy0),
        .cpu_hold(hold0), .busy(busy0), .done(done0), .count(cnt0)
`ifdef ARRAY_LOADER_CHECKSUM_EN
        , .checksum(cs0)
`endif
    );

    array_loader #(.BASE_ADDR(64'h100), .NUM_ELEMS(3)) dut1 (
        .clk(clk), .reset(rst), .start(start1), .load_data(ld1),
        .mem_addr(addr1), .mem_wdata(wd1), .mem_we(we1), .mem_ready(rdy1),
        .cpu_hold(hold1), .busy(busy1), .done(done1), .count(cnt1)
`ifdef ARRAY_LOADER_CHECKSUM_EN
        , .checksum(cs1)
`endif
    );

    function automatic logic [511:0] pk(input logic [63:0] e1, e2, e3, e4, e5, e6, e7, e8);
        return {e8, e7, e6, e5, e4, e3, e2, e1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor for instance 0: every presented write must match the queue head.
    always @(negedge clk) begin
        if (we0 === 1'b1) begin
            we_cyc0++;
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL dut0_extra_write got addr=0x%0h data=0x%0h expected none", addr0, wd0);
            end else begin
                if (addr0 !== q0[0].a || wd0 !== q0[0].d) begin
                    errors++;
                    $display("FAIL dut0_write got addr=0x%0h data=0x%0h expected addr=0x%0h data=0x%0h",
                             addr0, wd0, q0[0].a, q0[0].d);
                end
                if (rdy0) void'(q0.pop_front());
            end
        end
    end

    // Monitor for instance 1.
    always @(negedge clk) begin
        if (we1 === 1'b1) begin
            we_cyc1++;
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_extra_write got addr=0x%0h data=0x%0h expected none", addr1, wd1);
            end else begin
                if (addr1 !== q1[0].a || wd1 !== q1[0].d) begin
                    errors++;
                    $display("FAIL dut1_write got addr=0x%0h data=0x%0h expected addr=0x%0h data=0x%0h",
                             addr1, wd1, q1[0].a, q1[0].d);
                end
                if (rdy1) void'(q1.pop_front());
            end
        end
    end

    // Pulse start for one cycle and queue the expected write sequence.
    task automatic launch(input int which, input logic [511:0] d);
        wr_t w;
        int  n;
        logic [63:0] base;
        n    = (which == 0) ? 8 : 3;
        base = (which == 0) ? 64'h0 : 64'h100;
        for (int k = 0; k < n; k++) begin
            w.a = base + 64'(8 * k);
            w.d = d[64*k +: 64];
            if (which == 0) q0.push_back(w); else q1.push_back(w);
        end
        if (which == 0) begin
            we_cyc0 = 0; ld0 = d; start0 = 1'b1;
        end else begin
            we_cyc1 = 0; ld1 = d; start1 = 1'b1;
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int which, output int n);
        n = 0;
        while (((which == 0) ? done0 : done1) !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_done%0d got timeout expected done", which);
        end
    endtask

    task automatic wait_count0(input logic [3:0] target);
        int n;
        n = 0;
        while (cnt0 !== target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_count got timeout expected count=%0d", target);
        end
    endtask

    logic [511:0] d_main;
    int           lat;

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ld0 = '0; ld1 = '0; rdy0 = 1'b1; rdy1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        chk("rst_we", 64'(we0), 64'd0);
        chk("rst_addr", addr0, 64'd0);
        chk("rst_wdata", wd0, 64'd0);
        chk("rst_count", 64'(cnt0), 64'd0);
        chk("rst_hold", 64'(hold0), 64'd1);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);

        // Basic load, ready tied high: 8 writes, done 8 edges after start sampled.
        d_main = pk(5, 3, 8, 1, 9, 2, 7, 4);
        launch(0, d_main);
        chk("busy_in_write", 64'(busy0), 64'd1);
        chk("hold_in_write", 64'(hold0), 64'd1);
        wait_done(0, lat);
        chk("latency", 64'(lat), 64'd8);
        chk("wr_cycles_basic", 64'(we_cyc0), 64'd8);
        chk("done_count", 64'(cnt0), 64'd8);
        chk("done_hold", 64'(hold0), 64'd0);
        chk("done_busy", 64'(busy0), 64'd0);
        chk("done_we", 64'(we0), 64'd0);
        chk("q0_drained_basic", 64'(q0.size()), 64'd0);
`ifdef ARRAY_LOADER_CHECKSUM_EN
        chk("checksum_39", cs0, 64'd39);
`endif
        repeat (2) @(posedge clk); #1;
        chk("done_held", 64'(done0), 64'd1);

        // Backpressure: ready low 3 cycles while element 3 is presented.
        launch(0, d_main);
        wait_count0(4'd2);
        rdy0 = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("stall_count_hold", 64'(cnt0), 64'd2);
        rdy0 = 1'b1;
        wait_done(0, lat);
        chk("wr_cycles_stall", 64'(we_cyc0), 64'd11);
        chk("q0_drained_stall", 64'(q0.size()), 64'd0);

        // start and load_data changes during WRITE are ignored.
        launch(0, pk(11, 12, 13, 14, 15, 16, 17, 18));
        wait_count0(4'd3);
        ld0 = pk(99, 98, 97, 96, 95, 94, 93, 92);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        chk("ignored_start_count", 64'(cnt0), 64'd4);
        wait_done(0, lat);
        chk("wr_cycles_ignore", 64'(we_cyc0), 64'd8);
        chk("ignore_done_count", 64'(cnt0), 64'd8);
        chk("q0_drained_ignore", 64'(q0.size()), 64'd0);

        // Reset during element 5 aborts the load.
        launch(0, d_main);
        wait_count0(4'd4);
        rdy0 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rdy0 = 1'b1;
        q0.delete();
        chk("abort_we", 64'(we0), 64'd0);
        chk("abort_count", 64'(cnt0), 64'd0);
        chk("abort_hold", 64'(hold0), 64'd1);
        chk("abort_done", 64'(done0), 64'd0);
        chk("abort_addr", addr0, 64'd0);
        repeat (2) @(posedge clk); #1;
        chk("abort_idle_we", 64'(we0), 64'd0);
        launch(0, pk(21, 22, 23, 24, 25, 26, 27, 28));
        wait_done(0, lat);
        chk("fresh_wr_cycles", 64'(we_cyc0), 64'd8);
        chk("q0_drained_fresh", 64'(q0.size()), 64'd0);

`ifdef ARRAY_LOADER_CHECKSUM_EN
        // Checksum wraps modulo 2^64.
        launch(0, pk(64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 0, 0, 0, 0, 0));
        chk("checksum_cleared", cs0, 64'd0);
        wait_done(0, lat);
        chk("checksum_wrap", cs0, 64'd1);
`endif

        // Second instance: BASE_ADDR=0x100, three elements, restart from DONE.
        launch(1, pk(1, 2, 3, 0, 0, 0, 0, 0));
        wait_done(1, lat);
        chk("d1_latency", 64'(lat), 64'd3);
        chk("d1_done_count", 64'(cnt1), 64'd3);
        launch(1, pk(10, 20, 30, 0, 0, 0, 0, 0));
        chk("d1_restart_done", 64'(done1), 64'd0);
        chk("d1_restart_hold", 64'(hold1), 64'd1);
        chk("d1_restart_busy", 64'(busy1), 64'd1);
        wait_done(1, lat);
        chk("d1_done", 64'(done1), 64'd1);
        chk("d1_wr_cycles", 64'(we_cyc1), 64'd3);
        chk("q1_drained", 64'(q1.size()), 64'd0);
`ifdef ARRAY_LOADER_CHECKSUM_EN
        chk("d1_checksum", cs1, 64'd60);
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
